// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM states,
// sample positions inside a bit, majority/parity helpers and baud divider.
package uart_pkg;

  localparam int unsigned SmpW = 4;

  localparam logic [SmpW-1:0] SMP_VOTE_A = 4'd7;
  localparam logic [SmpW-1:0] SMP_VOTE_B = 4'd8;
  localparam logic [SmpW-1:0] SMP_VOTE_C = 4'd9;
  localparam logic [SmpW-1:0] SMP_LAST   = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Clocks per oversample tick, truncated toward zero.
  function automatic int unsigned calc_div(input int unsigned clk_fre,
                                           input int unsigned baud,
                                           input int unsigned os);
    return clk_fre / (baud * os);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity bit a transmitter would append to d.
  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous show-ahead byte FIFO: head byte is registered so it is
// available with no read latency; reports occupancy and dropped pushes.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [7:0]            wdata_i,
  input  logic                  ready_i,
  output logic [7:0]            rdata_o,
  output logic                  valid_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;

  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_q, wr_d;
  logic [DEPTH_LOG2-1:0] rd_q, rd_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [7:0]            head_q, head_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  full_c, pop_c, wr_en_c;

  always_comb begin
    full_c  = (count_q == CntW'(Depth));
    pop_c   = valid_q & ready_i;
    wr_en_c = push_i & (~full_c | pop_c);
    ovf_d   = push_i & full_c & ~pop_c;
    wr_d    = wr_en_c ? wr_q + DEPTH_LOG2'(1) : wr_q;
    rd_d    = pop_c ? rd_q + DEPTH_LOG2'(1) : rd_q;
    count_d = count_q;
    if (wr_en_c && !pop_c) begin
      count_d = count_q + CntW'(1);
    end else if (!wr_en_c && pop_c) begin
      count_d = count_q - CntW'(1);
    end
    valid_d = (count_d != '0);
    // New head is the byte being written when it lands in the slot being read.
    head_d  = (wr_en_c && (rd_d == wr_q)) ? wdata_i : mem_q[rd_d];
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      head_q  <= head_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rdata_o    = head_q;
  assign valid_o    = valid_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/uart_rx_os.sv
// UART receiver with 16x oversampling, 7/8/9 majority vote and byte FIFO.
// Define UART_PARITY_EN for 8-bit + parity frames (default build is 8N1).
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE         = 50000000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned OVERSAMPLE      = 16,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned PARITY_ODD      = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx,
  output logic [7:0]                 rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
  output logic                       frame_err,
  output logic                       overrun,
  output logic                       parity_err
);

  localparam int unsigned Div  = calc_div(CLK_FRE, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned DivW = (Div > 1) ? $clog2(Div) : 1;

  logic            rx_meta_q, rx_sync_q;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            tick_c;

  rx_state_e       state_q, state_d;
  logic [SmpW-1:0] smp_q, smp_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      vote_q, vote_d;
  logic            drop_q, drop_d;
  logic            frame_err_q, frame_err_d;
  logic            parity_err_q, parity_err_d;
  logic            push_c, bit_val_c, stop_val_c;

  // Free-running oversample tick.
  always_comb begin
    tick_c    = (div_cnt_q == DivW'(Div - 1));
    div_cnt_d = tick_c ? '0 : div_cnt_q + DivW'(1);
  end

  always_comb begin
    state_d      = state_q;
    smp_d        = smp_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    vote_d       = vote_q;
    drop_d       = drop_q;
    push_c       = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    bit_val_c    = majority3(vote_q[0], vote_q[1], vote_q[2]);
    // Stop is decided on sample 9 itself, so the live sample is the third vote.
    stop_val_c   = majority3(vote_q[0], vote_q[1], rx_sync_q);

    if (tick_c && (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})) begin
      smp_d = smp_q + SmpW'(1);
      if (smp_q == SMP_VOTE_A) vote_d[0] = rx_sync_q;
      if (smp_q == SMP_VOTE_B) vote_d[1] = rx_sync_q;
      if (smp_q == SMP_VOTE_C) vote_d[2] = rx_sync_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          state_d = ST_START;
          smp_d   = '0;
        end
      end
      ST_START: begin
        if (tick_c && (smp_q == SMP_LAST)) begin
          if (!bit_val_c) begin
            state_d = ST_DATA;
            bit_d   = '0;
            drop_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick_c && (smp_q == SMP_LAST)) begin
          shift_d = {bit_val_c, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (tick_c && (smp_q == SMP_LAST)) begin
          if (bit_val_c != parity_bit(shift_q, 1'(PARITY_ODD))) begin
            parity_err_d = 1'b1;
            drop_d       = 1'b1;
          end
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick_c && (smp_q == SMP_VOTE_C)) begin
          push_c      = stop_val_c & ~drop_q;
          frame_err_d = ~stop_val_c;
          state_d     = stop_val_c ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rx_sync_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifndef UART_PARITY_EN
  // PARITY_ODD only selects the parity sense; 8N1 frames carry no parity bit.
  if (PARITY_ODD > 1) begin : g_parity_odd_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      div_cnt_q    <= '0;
      state_q      <= ST_IDLE;
      smp_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      vote_q       <= '0;
      drop_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      div_cnt_q    <= div_cnt_d;
      state_q      <= state_d;
      smp_q        <= smp_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      vote_q       <= vote_d;
      drop_q       <= drop_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  uart_byte_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push_c),
    .wdata_i    (shift_q),
    .ready_i    (rx_ready),
    .rdata_o    (rx_data),
    .valid_o    (rx_valid),
    .count_o    (fifo_count),
    .overflow_o (overrun)
  );

  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed frames plus random traffic,
// compared against a byte-queue model of the receiver's frame rules.
`timescale 1ns/1ps
module tb_uart_rx_os;

  localparam int unsigned CLK_FRE    = 7_400_000;
  localparam int unsigned BAUD_RATE  = 115_200;
  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
  localparam int unsigned PARITY_ODD = 0;
  localparam int unsigned DIV        = CLK_FRE / (BAUD_RATE * 16);
  localparam int unsigned BIT_CLKS   = DIV * 16;
`ifdef UART_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  rx;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic                  frame_err;
  logic                  overrun;
  logic                  parity_err;

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  int fe_seen = 0, ov_seen = 0, pe_seen = 0;
  int exp_fe = 0, exp_ov = 0, exp_pe = 0;
  logic [7:0] q_exp[$];

  uart_rx_os #(
    .CLK_FRE         (CLK_FRE),
    .BAUD_RATE       (BAUD_RATE),
    .OVERSAMPLE      (16),
    .FIFO_DEPTH_LOG2 (DEPTH_LOG2),
    .PARITY_ODD      (PARITY_ODD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset === 1'b0) begin
      if (frame_err === 1'b1)  fe_seen++;
      if (overrun === 1'b1)    ov_seen++;
      if (parity_err === 1'b1) pe_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Receiver rules: bad stop -> frame error; bad parity -> parity error;
  // a good frame is queued unless the queue already holds DEPTH bytes.
  task automatic model_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
    logic par_fail;
    par_fail = PARITY_EN && bad_par;
    if (!stop_bit) exp_fe++;
    if (par_fail) exp_pe++;
    if (stop_bit && !par_fail) begin
      if (q_exp.size() >= DEPTH) exp_ov++;
      else q_exp.push_back(d);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
    rx = 1'b0;
    step(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(BIT_CLKS);
    end
    if (PARITY_EN) begin
      rx = (^d) ^ 1'(PARITY_ODD) ^ bad_par;
      step(BIT_CLKS);
    end
    rx = stop_bit;
    step(BIT_CLKS);
    rx = 1'b1;
    step(2 * DIV);
    model_frame(d, stop_bit, bad_par);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(fifo_count), 32'(q_exp.size()));
    check({tag, "_valid"}, 32'(rx_valid), 32'(q_exp.size() != 0));
    check({tag, "_frame_err"}, 32'(fe_seen), 32'(exp_fe));
    check({tag, "_overrun"}, 32'(ov_seen), 32'(exp_ov));
    check({tag, "_parity_err"}, 32'(pe_seen), 32'(exp_pe));
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] exp_b;
    exp_b = 8'h00;
    if (q_exp.size() > 0) exp_b = q_exp.pop_front();
    check({tag, "_pop_valid"}, 32'(rx_valid), 32'd1);
    check({tag, "_pop_data"}, 32'(rx_data), 32'(exp_b));
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (q_exp.size() > 0) pop_one(tag);
    step(1);
    check({tag, "_drained_count"}, 32'(fifo_count), 32'd0);
    check({tag, "_drained_valid"}, 32'(rx_valid), 32'd0);
  endtask

  task automatic align_tick();
    while ((cyc % DIV) != 0) step(1);
  endtask

  initial begin
    int unsigned t0, t_inc, lat;
    logic [7:0] b;

    reset = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b0;
    step(5);
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_data", 32'(rx_data), 32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_parity_err", 32'(parity_err), 32'd0);
    reset = 1'b0;
    step(3 * DIV);

    send_frame(8'hA5, 1'b1, 1'b0);
    check_status("a5");
    pop_one("a5");
    check_status("a5_after_pop");

    rx = 1'b0;
    step(BIT_CLKS / 4);
    rx = 1'b1;
    step(2 * BIT_CLKS);
    check_status("glitch");
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b0);
    check_status("post_glitch");
    drain("post_glitch");

    send_frame(8'h3C, 1'b0, 1'b0);
    check_status("stop_low");
    send_frame(8'h55, 1'b1, 1'b0);
    check_status("after_break");
    drain("after_break");

    // Reset mid-frame with a byte already queued.
    send_frame(8'($urandom), 1'b1, 1'b0);
    rx = 1'b0;
    step(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rx = 1'($urandom);
      step(BIT_CLKS);
    end
    reset = 1'b1;
    rx = 1'b1;
    step(3);
    check("midreset_data", 32'(rx_data), 32'd0);
    reset = 1'b0;
    q_exp.delete();
    step(12 * BIT_CLKS);
    check_status("midreset");

    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 1'b0);
    check_status("overrun");
    drain("overrun");

    // Fill to DEPTH-1, measure when the next byte lands, then repeat at full.
    for (int i = 0; i < DEPTH - 1; i++) send_frame(8'($urandom), 1'b1, 1'b0);
    check_status("prefill");
    align_tick();
    t0 = cyc;
    t_inc = 0;
    fork
      send_frame(8'($urandom), 1'b1, 1'b0);
      begin
        for (int i = 0; i < 12 * BIT_CLKS; i++) begin
          step(1);
          if (t_inc == 0 && fifo_count == (DEPTH_LOG2 + 1)'(DEPTH)) t_inc = cyc;
        end
      end
    join
    check("calib_seen_full", 32'(t_inc != 0), 32'd1);
    check_status("full");
    lat = (t_inc > t0 + 1) ? t_inc - t0 : 2;
    align_tick();
    fork
      send_frame(8'($urandom), 1'b1, 1'b0);
      begin
        step(lat - 1);
        pop_one("full_pushpop");
      end
    join
    check_status("full_pushpop");
    drain("full_pushpop");

    for (int n = 0; n < 6; n++) begin
      step($urandom_range(0, 2 * BIT_CLKS));
      send_frame(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
      check_status("random");
      if (q_exp.size() > 0 && $urandom_range(0, 1) == 1) pop_one("random");
    end
    drain("random");

    if (PARITY_EN) begin
      send_frame(8'h01, 1'b1, 1'b1);
      check_status("parity_bad");
      send_frame(8'h01, 1'b1, 1'b0);
      check_status("parity_good");
      drain("parity_good");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
